// File: rtl/bp_me_stream_pkg.sv
// bp_me_stream_pkg: message types, header layout and beat-count helper shared by
// the BP-Lite / BP-Stream serializer and its sub-modules.
`ifndef BP_ME_STREAM_PKG_SV
`define BP_ME_STREAM_PKG_SV

// Header layout, msg_type at the LSBs. Expanded inside a module so the address
// and payload widths follow that module's parameters.
`define BP_ME_STREAM_HDR_S(paddr_w, payload_w) \
    typedef struct packed { \
        logic [payload_w-1:0] payload; \
        logic [2:0]           size; \
        logic [paddr_w-1:0]   addr; \
        mem_msg_type_e        msg_type; \
    } mem_header_s

package bp_me_stream_pkg;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'd0,
        e_mem_msg_wr    = 4'd1,
        e_mem_msg_uc_rd = 4'd2,
        e_mem_msg_uc_wr = 4'd3,
        e_mem_msg_pre   = 4'd4
    } mem_msg_type_e;

    function automatic logic msg_is_wr(mem_msg_type_e t);
        return (t == e_mem_msg_uc_wr) || (t == e_mem_msg_wr);
    endfunction

    // Commands carry data on writes, responses carry data on reads.
    function automatic logic msg_has_data(mem_msg_type_e t, bit master);
        return master ? msg_is_wr(t) : !msg_is_wr(t);
    endfunction

    // Beats needed for one message: one per out_bytes of payload, at least one,
    // saturating at the number of lanes in the wide data word.
    function automatic int unsigned beat_count(logic has_data, logic [2:0] size,
                                               int unsigned out_bytes,
                                               int unsigned stream_words);
        int unsigned n;
        n = (32'd1 << size) / out_bytes;
        if (n == 32'd0) n = 32'd1;
        if (n > stream_words) n = stream_words;
        return has_data ? n : 32'd1;
    endfunction

endpackage

`endif

// File: rtl/bp_lite_to_stream_if.sv
// bp_lite_to_stream_if: Lite-side input and Stream-side output signals of the
// serializer, plus a debug view of its FSM state.
//
// Handshake rule on both sides: a transfer happens on a rising clock edge where
// valid and ready are both high. Valid never waits for ready, and once valid is
// raised its payload stays stable until the transfer completes.
interface bp_lite_to_stream_if #(
    parameter int paddr_width_p    = 40,
    parameter int in_data_width_p  = 512,
    parameter int out_data_width_p = 64,
    parameter int payload_width_p  = 16
);
    localparam int hdr_w = 4 + paddr_width_p + 3 + payload_width_p;

    logic [hdr_w-1:0]            mem_header_i;
    logic [in_data_width_p-1:0]  mem_data_i;
    logic                        mem_v_i;
    logic                        mem_ready_o;

    logic [hdr_w-1:0]            mem_header_o;
    logic [out_data_width_p-1:0] mem_data_o;
    logic                        mem_v_o;
    logic                        mem_ready_i;
    logic                        mem_lock_o;

    logic [1:0]                  dbg_state;

    modport slave (
        input  mem_header_i, mem_data_i, mem_v_i, mem_ready_i,
        output mem_ready_o, mem_header_o, mem_data_o, mem_v_o, mem_lock_o, dbg_state
    );

    modport master (
        output mem_header_i, mem_data_i, mem_v_i, mem_ready_i,
        input  mem_ready_o, mem_header_o, mem_data_o, mem_v_o, mem_lock_o, dbg_state
    );
endinterface

// File: rtl/bp_stream_beat_gen.sv
// bp_stream_beat_gen: beat counter plus per-beat lane and address generation.
// Optional macro BP_LITE_TO_STREAM_WRAP_EN selects critical-word-first order;
// without it beats always start at lane 0 of the aligned block.
module bp_stream_beat_gen #(
    parameter int paddr_width_p    = 40,
    parameter int out_data_width_p = 64,
    parameter int stream_words_p   = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              start_i,
    input  logic                              adv_i,
    input  logic [$clog2(stream_words_p):0]   beats_i,
    input  logic [paddr_width_p-1:0]          addr_i,
    input  logic [2:0]                        size_i,
    output logic                              last_o,
    output logic [$clog2(stream_words_p)-1:0] lane_o,
    output logic [paddr_width_p-1:0]          addr_o
);
    localparam int lane_w = $clog2(stream_words_p);
    localparam int off_w  = $clog2(out_data_width_p / 8);
    localparam logic [2:0] off_sz = 3'(off_w);

    logic [lane_w:0]          cnt;
    logic [paddr_width_p-1:0] size_mask;
    logic [paddr_width_p-1:0] base;
    logic [lane_w-1:0]        lane_mask;
    logic [lane_w-1:0]        start;

    // Beat counter: cleared when a message is captured, stepped per handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)  cnt <= '0;
        else if (start_i) cnt <= '0;
        else if (adv_i)   cnt <= last_o ? '0 : cnt + 1'b1;
    end

    assign last_o = (cnt == beats_i - 1'b1);

    // Lane and address of the current beat. Beat counts are powers of two, so
    // the modulo over the beat count is a mask.
    always_comb begin
        size_mask = (paddr_width_p'(1) << size_i) - paddr_width_p'(1);
        base      = addr_i & ~size_mask;
        lane_mask = lane_w'(beats_i - 1'b1);
`ifdef BP_LITE_TO_STREAM_WRAP_EN
        start     = lane_w'((addr_i & size_mask) >> off_w);
`else
        start     = '0;
`endif
        lane_o    = (start + lane_w'(cnt)) & lane_mask;
        if (size_i < off_sz) addr_o = addr_i;
        else                 addr_o = base + (paddr_width_p'(lane_o) << off_w);
    end
endmodule

// File: rtl/bp_lite_to_stream.sv
// bp_lite_to_stream: serializes one BP-Lite message (header + wide data) into a
// BP-Stream of narrow beats, each with its own header and lock flag.
// Optional macro BP_LITE_TO_STREAM_WRAP_EN enables critical-word-first order.
module bp_lite_to_stream
    import bp_me_stream_pkg::*;
#(
    parameter int paddr_width_p    = 40,
    parameter int in_data_width_p  = 512,
    parameter int out_data_width_p = 64,
    parameter bit master_p         = 0,
    parameter int payload_width_p  = 16
) (
    input logic               clk_i,
    input logic               reset_n_i,
    bp_lite_to_stream_if.slave io
);
    localparam int out_bytes_lp    = out_data_width_p / 8;
    localparam int stream_words_lp = in_data_width_p / out_data_width_p;
    localparam int cnt_w_lp        = $clog2(stream_words_lp) + 1;
    localparam int lane_w_lp       = $clog2(stream_words_lp);

    localparam logic [1:0] e_reset  = 2'd0;
    localparam logic [1:0] e_ready  = 2'd1;
    localparam logic [1:0] e_stream = 2'd2;

    `BP_ME_STREAM_HDR_S(paddr_width_p, payload_width_p);

    mem_header_s                in_hdr;
    mem_header_s                hdr_r;
    mem_header_s                out_hdr;
    logic [in_data_width_p-1:0] data_r;
    logic [cnt_w_lp-1:0]        beats_r;
    logic [cnt_w_lp-1:0]        in_beats;
    logic                       has_data_r;
    logic                       in_has_data;
    logic [1:0]                 state_r;
    logic                       accept;
    logic                       beat_hs;
    logic                       last;
    logic [lane_w_lp-1:0]       lane;
    logic [paddr_width_p-1:0]   beat_addr;

    assign in_hdr      = io.mem_header_i;
    assign in_has_data = msg_has_data(in_hdr.msg_type, master_p);
    assign in_beats    = cnt_w_lp'(beat_count(in_has_data, in_hdr.size,
                                              out_bytes_lp, stream_words_lp));
    assign accept      = (state_r == e_ready) && io.mem_v_i;
    assign beat_hs     = (state_r == e_stream) && io.mem_ready_i;

    // Control: leave reset, take one message in e_ready, drain it in e_stream.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_reset;
        end else begin
            case (state_r)
                e_reset:  state_r <= e_ready;
                e_ready:  if (io.mem_v_i) state_r <= e_stream;
                e_stream: if (beat_hs && last) state_r <= e_ready;
                default:  state_r <= e_ready;
            endcase
        end
    end

    // Capture the accepted message; it stays put while its beats go out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_r      <= '0;
            data_r     <= '0;
            beats_r    <= '0;
            has_data_r <= 1'b0;
        end else if (accept) begin
            hdr_r      <= in_hdr;
            data_r     <= io.mem_data_i;
            beats_r    <= in_beats;
            has_data_r <= in_has_data;
        end
    end

    bp_stream_beat_gen #(
        .paddr_width_p   (paddr_width_p),
        .out_data_width_p(out_data_width_p),
        .stream_words_p  (stream_words_lp)
    ) beat_gen (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .start_i  (accept),
        .adv_i    (beat_hs),
        .beats_i  (beats_r),
        .addr_i   (hdr_r.addr),
        .size_i   (hdr_r.size),
        .last_o   (last),
        .lane_o   (lane),
        .addr_o   (beat_addr)
    );

    // Per-beat header: the captured header with the beat's own address.
    always_comb begin
        out_hdr      = hdr_r;
        out_hdr.addr = beat_addr;
    end

    assign io.mem_header_o = out_hdr;
    assign io.mem_data_o   = has_data_r
                           ? data_r[int'(lane)*out_data_width_p +: out_data_width_p]
                           : '0;
    assign io.mem_ready_o  = (state_r == e_ready);
    assign io.mem_v_o      = (state_r == e_stream);
    assign io.mem_lock_o   = (state_r == e_stream) && !last;
    assign io.dbg_state    = state_r;
endmodule

// File: tb/tb_bp_lite_to_stream.sv
// tb_bp_lite_to_stream: directed bench for bp_lite_to_stream, 512/64 build, with
// one command-source (master_p=1) and one response-source (master_p=0) instance.
module tb_bp_lite_to_stream;
  import bp_me_stream_pkg::*;

  localparam int paddr_w = 40;
  localparam int in_w    = 512;
  localparam int out_w   = 64;
  localparam int pl_w    = 16;
  localparam int bw      = 16 + 3 + 40 + 4 + 64 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [bw-1:0] exp_m_q[$];
  logic [bw-1:0] exp_c_q[$];

  bp_lite_to_stream_if #(.paddr_width_p(paddr_w), .in_data_width_p(in_w),
                         .out_data_width_p(out_w), .payload_width_p(pl_w)) m_if ();
  bp_lite_to_stream_if #(.paddr_width_p(paddr_w), .in_data_width_p(in_w),
                         .out_data_width_p(out_w), .payload_width_p(pl_w)) c_if ();

  bp_lite_to_stream #(.paddr_width_p(paddr_w), .in_data_width_p(in_w),
                      .out_data_width_p(out_w), .master_p(1'b1),
                      .payload_width_p(pl_w)) dut_m (
    .clk_i(clk), .reset_n_i(rst_n), .io(m_if));

  bp_lite_to_stream #(.paddr_width_p(paddr_w), .in_data_width_p(in_w),
                      .out_data_width_p(out_w), .master_p(1'b0),
                      .payload_width_p(pl_w)) dut_c (
    .clk_i(clk), .reset_n_i(rst_n), .io(c_if));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [bw-1:0] act, input logic [bw-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: beats a message needs, from message type and size
  function automatic int model_beats(input bit client, input mem_msg_type_e mt,
                                     input logic [2:0] size);
    bit is_wr;
    bit has_data;
    int n;
    is_wr    = (mt == e_mem_msg_wr) || (mt == e_mem_msg_uc_wr);
    has_data = client ? !is_wr : is_wr;
    n = (1 << size) / 8;
    if (n < 1) n = 1;
    if (n > 8) n = 8;
    return has_data ? n : 1;
  endfunction

  // model: beat k as {header, data, lock}
  function automatic logic [bw-1:0] model_beat(input bit client, input mem_msg_type_e mt,
                                               input logic [2:0] size, input logic [39:0] addr,
                                               input logic [15:0] pl, input logic [511:0] data,
                                               input int k);
    int nbytes;
    int beats;
    int start;
    int lane;
    bit is_wr;
    bit has_data;
    logic [39:0] base;
    logic [39:0] baddr;
    logic [63:0] bdata;
    nbytes   = 1 << size;
    beats    = model_beats(client, mt, size);
    is_wr    = (mt == e_mem_msg_wr) || (mt == e_mem_msg_uc_wr);
    has_data = client ? !is_wr : is_wr;
    base     = addr & ~(40'(nbytes) - 40'd1);
`ifdef BP_LITE_TO_STREAM_WRAP_EN
    start    = int'(addr % 40'(nbytes)) / 8;
`else
    start    = 0;
`endif
    lane     = (start + k) % beats;
    baddr    = (nbytes < 8) ? addr : base + 40'(lane * 8);
    bdata    = has_data ? data[lane*64 +: 64] : 64'd0;
    return {pl, size, baddr, mt, bdata, (k != beats - 1)};
  endfunction

  // driver: offer one Lite message, wait (bounded) for ready, queue its beats
  task automatic send(input bit client, input mem_msg_type_e mt, input logic [2:0] size,
                      input logic [39:0] addr, input logic [15:0] pl, input logic [511:0] data);
    int waited;
    logic rdy;
    waited = 0;
    rdy = client ? c_if.mem_ready_o : m_if.mem_ready_o;
    while (!rdy && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      rdy = client ? c_if.mem_ready_o : m_if.mem_ready_o;
    end
    check("send_ready", rdy, 1'b1);
    if (!rdy) return;
    for (int k = 0; k < model_beats(client, mt, size); k++) begin
      if (client) exp_c_q.push_back(model_beat(client, mt, size, addr, pl, data, k));
      else        exp_m_q.push_back(model_beat(client, mt, size, addr, pl, data, k));
    end
    if (client) begin
      c_if.mem_header_i = {pl, size, addr, mt};
      c_if.mem_data_i   = data;
      c_if.mem_v_i      = 1'b1;
    end else begin
      m_if.mem_header_i = {pl, size, addr, mt};
      m_if.mem_data_i   = data;
      m_if.mem_v_i      = 1'b1;
    end
    @(posedge clk); #1;
    c_if.mem_v_i = 1'b0;
    m_if.mem_v_i = 1'b0;
  endtask

  // driver: wait (bounded) until every expected beat has been seen
  task automatic drain(input bit client, input int max_cycles, output int cycles);
    int left;
    cycles = 0;
    left = client ? exp_c_q.size() : exp_m_q.size();
    while (left != 0 && cycles < max_cycles) begin
      @(posedge clk); #1;
      cycles++;
      left = client ? exp_c_q.size() : exp_m_q.size();
    end
    if (client) check("c_drain_left", left, 0);
    else        check("m_drain_left", left, 0);
    exp_c_q.delete();
    exp_m_q.delete();
  endtask

  // scoreboard: every cycle a beat is valid it must equal the queue head;
  // the head is retired only on a handshake, so held beats are re-checked.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.mem_v_o) begin
        if (exp_m_q.size() == 0) check("m_extra_beat", m_if.mem_v_o, 1'b0);
        else begin
          check("m_beat", {m_if.mem_header_o, m_if.mem_data_o, m_if.mem_lock_o}, exp_m_q[0]);
          if (m_if.mem_ready_i) void'(exp_m_q.pop_front());
        end
      end else check("m_idle_lock", m_if.mem_lock_o, 1'b0);
      if (c_if.mem_v_o) begin
        if (exp_c_q.size() == 0) check("c_extra_beat", c_if.mem_v_o, 1'b0);
        else begin
          check("c_beat", {c_if.mem_header_o, c_if.mem_data_o, c_if.mem_lock_o}, exp_c_q[0]);
          if (c_if.mem_ready_i) void'(exp_c_q.pop_front());
        end
      end else check("c_idle_lock", c_if.mem_lock_o, 1'b0);
    end
  end

  initial begin
    int cyc;
    logic [511:0] d;
    logic [511:0] r;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'((i + 1) * 17);
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = {$urandom, $urandom};
    m_if.mem_header_i = '0; m_if.mem_data_i = '0; m_if.mem_v_i = 1'b0; m_if.mem_ready_i = 1'b1;
    c_if.mem_header_i = '0; c_if.mem_data_i = '0; c_if.mem_v_i = 1'b0; c_if.mem_ready_i = 1'b1;

    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_m_ready", m_if.mem_ready_o, 1'b0);
    check("rst_m_v", m_if.mem_v_o, 1'b0);
    check("rst_m_lock", m_if.mem_lock_o, 1'b0);
    check("rst_c_ready", c_if.mem_ready_o, 1'b0);
    rst_n = 1'b1; #1;
    check("rel_m_ready_before_edge", m_if.mem_ready_o, 1'b0);
    @(posedge clk); #1;
    check("rel_m_ready", m_if.mem_ready_o, 1'b1);
    check("rel_c_ready", c_if.mem_ready_o, 1'b1);

    // 1: 8-beat write at full throughput
    check("pin_t1_b0", model_beat(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0040, 16'hbeef, d, 0),
          {16'hbeef, 3'd6, 40'h80_0000_0040, 4'd1, 64'h11, 1'b1});
    check("pin_t1_b7", model_beat(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0040, 16'hbeef, d, 7),
          {16'hbeef, 3'd6, 40'h80_0000_0078, 4'd1, 64'h88, 1'b0});
    send(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0040, 16'hbeef, d);
    drain(0, 20, cyc);
    check("t1_cycles", cyc, 8);
    check("t1_ready_back", m_if.mem_ready_o, 1'b1);
    check("t1_v_low", m_if.mem_v_o, 1'b0);

    // 2: reads on the command side are one data-less beat; on the response side eight
    check("pin_t2_rd_m", model_beat(0, e_mem_msg_rd, 3'd6, 40'h80_0000_0040, 16'h0001, d, 0),
          {16'h0001, 3'd6, 40'h80_0000_0040, 4'd0, 64'h0, 1'b0});
    send(0, e_mem_msg_rd, 3'd6, 40'h80_0000_0040, 16'h0001, d);
    drain(0, 20, cyc);
    check("t2_m_cycles", cyc, 1);
    check("pin_t2_rd_c_beats", model_beats(1, e_mem_msg_rd, 3'd6), 8);
    send(1, e_mem_msg_rd, 3'd6, 40'h80_0000_0040, 16'h0002, r);
    drain(1, 20, cyc);
    check("t2_c_cycles", cyc, 8);
    send(1, e_mem_msg_wr, 3'd6, 40'h80_0000_0040, 16'h0003, r);
    drain(1, 20, cyc);
    check("t2_c_wr_cycles", cyc, 1);

    // 3: backpressure while beat 2 is on the bus
    send(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0080, 16'h0004, r);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_if.mem_ready_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t3_v_held", m_if.mem_v_o, 1'b1);
    m_if.mem_ready_i = 1'b1;
    drain(0, 20, cyc);
    check("t3_cycles", cyc, 6);

    // 4: sub-beat and exactly-one-beat sizes
    check("pin_t4_s2", model_beat(0, e_mem_msg_wr, 3'd2, 40'h80_0000_0044, 16'h0005, d, 0),
          {16'h0005, 3'd2, 40'h80_0000_0044, 4'd1, 64'h11, 1'b0});
    send(0, e_mem_msg_wr, 3'd2, 40'h80_0000_0044, 16'h0005, d);
    drain(0, 20, cyc);
    check("t4_s2_cycles", cyc, 1);
    check("pin_t4_s3", model_beat(0, e_mem_msg_uc_wr, 3'd3, 40'h80_0000_0044, 16'h0006, d, 0),
          {16'h0006, 3'd3, 40'h80_0000_0040, 4'd3, 64'h11, 1'b0});
    send(0, e_mem_msg_uc_wr, 3'd3, 40'h80_0000_0044, 16'h0006, d);
    drain(0, 20, cyc);

    // 5: unaligned multi-beat start, and size beyond the wide word
`ifdef BP_LITE_TO_STREAM_WRAP_EN
    check("pin_t5_b0", model_beat(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0058, 16'h0007, d, 0),
          {16'h0007, 3'd6, 40'h80_0000_0058, 4'd1, 64'h44, 1'b1});
    check("pin_t5_b5", model_beat(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0058, 16'h0007, d, 5),
          {16'h0007, 3'd6, 40'h80_0000_0040, 4'd1, 64'h11, 1'b1});
`else
    check("pin_t5_b0", model_beat(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0058, 16'h0007, d, 0),
          {16'h0007, 3'd6, 40'h80_0000_0040, 4'd1, 64'h11, 1'b1});
    check("pin_t5_b5", model_beat(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0058, 16'h0007, d, 5),
          {16'h0007, 3'd6, 40'h80_0000_0068, 4'd1, 64'h66, 1'b1});
`endif
    send(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0058, 16'h0007, d);
    drain(0, 20, cyc);
    check("t5_cycles", cyc, 8);
    check("pin_t5_sat_beats", model_beats(0, e_mem_msg_wr, 3'd7), 8);
    send(0, e_mem_msg_wr, 3'd7, 40'h80_0000_0040, 16'h0008, r);
    drain(0, 20, cyc);
    check("t5_sat_cycles", cyc, 8);

    // 6: reset in the middle of a message
    send(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0100, 16'h0009, d);
    repeat (4) @(posedge clk); #1;
    #2;
    rst_n = 1'b0; #1;
    check("t6_v_async", m_if.mem_v_o, 1'b0);
    check("t6_lock_async", m_if.mem_lock_o, 1'b0);
    check("t6_ready_async", m_if.mem_ready_o, 1'b0);
    exp_m_q.delete();
    exp_c_q.delete();
    repeat (2) @(posedge clk); #1;
    check("t6_ready_in_reset", m_if.mem_ready_o, 1'b0);
    rst_n = 1'b1; #1;
    check("t6_ready_before_edge", m_if.mem_ready_o, 1'b0);
    @(posedge clk); #1;
    check("t6_ready_after_edge", m_if.mem_ready_o, 1'b1);
    send(0, e_mem_msg_wr, 3'd6, 40'h80_0000_0100, 16'h000a, r);
    drain(0, 20, cyc);
    check("t6_cycles", cyc, 8);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_lite_to_stream.md
Name: bp_lite_to_stream

Overview:
- Serializer from BP-Lite to BP-Stream: accepts one full memory message (header plus wide data) and emits it as a stream of narrow beats, each beat carrying its own header.
- Counterpart of the stream-to-lite deserializer. It sits on the other end of the same memory link, e.g. between a wide cache/CCE port and a narrow NoC/DRAM stream port.
- master_p selects whether the stream carries commands (master) or responses (client).

Parameters:
- paddr_width_p, 40, physical address width
- in_data_width_p, 512, Lite data width (wide side)
- out_data_width_p, 64, Stream beat data width; in_data_width_p must be a multiple of it
- master_p, 0, 1 = command source (writes carry data), 0 = response source (reads carry data)
- payload_width_p, 16, opaque header payload width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- mem_header_i  in  hdr_w  Lite header; layout from package; hdr_w = 4+paddr_width_p+3+payload_width_p
- mem_data_i  in  in_data_width_p  Lite data; lane i = bytes at aligned base + i*out_bytes
- mem_v_i  in  1  Lite valid
- mem_ready_o  out  1  Lite ready (ready/valid)
- mem_header_o  out  hdr_w  per-beat Stream header
- mem_data_o  out  out_data_width_p  Stream beat data
- mem_v_o  out  1  Stream valid
- mem_ready_i  in  1  Stream ready (ready/valid)
- mem_lock_o  out  1  high on every beat except the last of a message

Behaviour:
- Derived values: out_bytes = out_data_width_p/8; stream_words = in/out ratio; is_wr = msg_type in {e_mem_msg_uc_wr, e_mem_msg_wr}; has_data = master_p ? is_wr : ~is_wr.
- Beat count: beats = has_data ? min(max((1<<size)/out_bytes, 1), stream_words) : 1. Counter width is clog2(stream_words)+1 so no truncation.
- FSM states: e_reset, e_ready, e_stream.
  - Reset asserted (asynchronous): state = e_reset, mem_ready_o = 0, mem_v_o = 0, mem_lock_o = 0, counter = 0.
  - e_reset -> e_ready on the first clock edge after reset release.
  - e_ready: mem_ready_o = 1, mem_v_o = 0. On mem_v_i & mem_ready_o, register header, data and beats; go to e_stream with counter = 0.
  - e_stream: mem_ready_o = 0, mem_v_o = 1. On mem_v_o & mem_ready_i, counter increments. On the handshake of the last beat (counter == beats-1), return to e_ready.
- Latency: message accepted at edge N; first beat valid in the cycle after N. There is one idle (ready) cycle between messages; there is no bypass and no comb path from mem_ready_i to mem_ready_o.
- Beat k header: identical to the captured header except addr.
  - addr = aligned base + k*out_bytes, where aligned base = addr with the low log2(1<<size) bits cleared.
  - Single-beat messages with size < out_bytes keep the original addr.
- Beat k data: lane k. Beats with has_data = 0 drive data = 0.
- Lock: mem_lock_o = (counter != beats-1) while mem_v_o is high; 0 otherwise.
- Backpressure: header, data and lock are held stable while mem_v_o & ~mem_ready_i. mem_v_o never drops before its handshake.
- Reset mid-stream: the message is discarded and no partial replay occurs. The next accepted message streams all of its beats.
- size > log2(in_data_width_p/8): beats saturate at stream_words.

Optional Feature:
- Macro: BP_LITE_TO_STREAM_WRAP_EN.
- Defined (critical-word-first): start = (addr mod (1<<size))/out_bytes. Beat k sends lane (start+k) mod beats, with addr = aligned base + ((start+k) mod beats)*out_bytes.
- Undefined: ordering from lane 0 exactly as in Behaviour; low addr bits are ignored for multi-beat messages.

Decomposition:
- Package bp_me_stream_pkg holds:
  - mem_msg_type_e (4-bit)
  - the header struct macro {payload, size[2:0], addr, msg_type}, with msg_type at LSBs
  - the beat-count function
- One sub-module, bp_stream_beat_gen: the counter plus address/lane-select generator with the wrap option. The top level owns the FSM and capture registers.

Test Plan (512/64, master_p=1 unless noted):
1. Wr size 6, addr 0x8000_0040, lanes 0..7 = 0x11..0x88, ready_i held 1 -> 8 beats, one per cycle; addrs 0x40,0x48,...,0x78; data 0x11..0x88; lock 1 on beats 0-6, 0 on beat 7; ready_o high again the cycle after beat 7.
2. Rd size 6 with master_p=1 -> 1 beat, lock 0, data 0. Same read with master_p=0 -> 8 beats.
3. Wr size 6, ready_i low during beats 2-4 -> beat 2 header/data held stable; all 8 beats delivered in order, none dropped or duplicated.
4. Wr size 2, addr 0x8000_0044 -> 1 beat, addr 0x8000_0044, data lane 0, lock 0.
5. WRAP_EN defined, wr size 6, addr 0x8000_0058 -> lanes 3,4,5,6,7,0,1,2 with addrs 0x58,0x60,0x68,0x70,0x78,0x40,0x48,0x50. Undefined -> lanes 0..7 from 0x40.
6. reset_n_i low after beat 3 of 8 -> v_o/lock_o drop to 0 without a clock edge; ready_o 0 during reset and 1 one cycle after release; a new message then streams all 8 beats.
